serial_subtractor_4bit: RTL and testbench

Bit-serial two's-complement subtractor that computes a − b − bin using one full-subtractor cell, one bit per clock, LSB first. It is the inverse arithmetic companion to the team's 4-bit adder datapath and is used where operand width matters more than latency. A start/busy/done handshake frames each operation. Results are held in output registers until the next operation completes.

---
 rtl/serial_subtractor_4bit_if.sv | 31 +++
 rtl/serial_subtractor_4bit.sv | 122 ++++++++++++
 tb/tb_serial_subtractor_4bit.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_4bit_if.sv
//==============================================================================
// Module  : serial_subtractor_4bit_if
// Brief   : Start/busy/done handshake and operand/result bus of the serial subtractor.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

interface serial_subtractor_4bit_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
endinterface

`default_nettype wire

// File: rtl/serial_subtractor_4bit.sv
//==============================================================================
// Module  : serial_subtractor_4bit
// Brief   : Bit-serial a - b - bin using one full-subtractor cell, LSB first.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module serial_subtractor_4bit #(
  parameter int WIDTH = 4
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  serial_subtractor_4bit_if.slave     bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH-1:0]   sb_q, sb_d;
  // Only WIDTH-1 bits are kept: the final result is the live bit plus these.
  logic [WIDTH-2:0]   wd_q, wd_d;
  logic               br_q, br_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic               w_d_bit;
  logic               w_br_next;
  logic [WIDTH-1:0]   w_wd_full;

  assign w_d_bit   = sa_q[0] ^ sb_q[0] ^ br_q;
  assign w_br_next = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
  assign w_wd_full = {w_d_bit, wd_q};

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    wd_d    = wd_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sa_d    = bus.a;
          sb_d    = bus.b;
          br_d    = bus.bin;
          cnt_d   = '0;
          wd_d    = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        br_d  = w_br_next;
        wd_d  = w_wd_full[WIDTH-1:1];
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == C_LAST) begin
          diff_d  = w_wd_full;
          bout_d  = w_br_next;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      wd_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      wd_q    <= wd_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor_4bit.sv
//==============================================================================
// Module  : tb_serial_subtractor_4bit
// Brief   : Directed plus randomized self-checking bench for serial_subtractor_4bit.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_serial_subtractor_4bit;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  serial_subtractor_4bit_if #(.WIDTH(W)) bus ();

  serial_subtractor_4bit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: plain integer arithmetic, borrow when the true result is negative.
  function automatic logic [W:0] ref_sub(input int a, input int b, input int bin);
    int r;
    r = a - b - bin;
    return {(r < 0) ? 1'b1 : 1'b0, W'(r & ((1 << W) - 1))};
  endfunction

  task automatic run_op(input int a, input int b, input int bin, input bit full, input string tag);
    logic [W:0] e;
    e = ref_sub(a, b, bin);
    bus.start = 1'b1;
    bus.a     = W'(a);
    bus.b     = W'(b);
    bus.bin   = bin[0];
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (full) begin
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        check({tag, "_nodone"}, 32'(bus.done), 32'd0);
      end
      tick();
    end
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_diff"}, 32'(bus.diff), 32'(e[W-1:0]));
    check({tag, "_bout"}, 32'(bus.bout), 32'(e[W]));
    if (full) check({tag, "_busy_lo"}, 32'(bus.busy), 32'd0);
    tick();
    if (full) check({tag, "_done_clr"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    logic [W:0] e;
    int ra, rb, rbin;

    // Reset with start asserted: reset must win.
    rst = 1'b1; bus.start = 1'b1; bus.a = W'(9); bus.b = W'(3); bus.bin = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_diff", 32'(bus.diff), 32'd0);
    check("rst_bout", 32'(bus.bout), 32'd0);
    rst = 1'b0; bus.start = 1'b0;
    tick();
    check("idle_busy", 32'(bus.busy), 32'd0);

    run_op(9, 3, 0, 1'b1, "op_9m3");
    run_op(3, 9, 0, 1'b1, "op_3m9");
    run_op(0, 0, 1, 1'b1, "op_0m0b");
    run_op(15, 15, 0, 1'b1, "op_FmF");

    // A second start while busy must be ignored.
    bus.start = 1'b1; bus.a = W'(5); bus.b = W'(2); bus.bin = 1'b0;
    tick();
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1; bus.a = W'(1); bus.b = W'(7);
    tick();
    bus.start = 1'b0;
    check("ign_busy", 32'(bus.busy), 32'd1);
    tick();
    tick();
    check("ign_done", 32'(bus.done), 32'd1);
    check("ign_diff", 32'(bus.diff), 32'd3);
    check("ign_bout", 32'(bus.bout), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ign_no_second_done", 32'(bus.done), 32'd0);
      check("ign_no_second_busy", 32'(bus.busy), 32'd0);
    end

    // Back-to-back with start held high.
    bus.start = 1'b1; bus.a = W'(9); bus.b = W'(3); bus.bin = 1'b0;
    tick();
    bus.a = W'(3); bus.b = W'(9);
    for (int i = 0; i < W; i++) tick();
    check("b2b_done1", 32'(bus.done), 32'd1);
    check("b2b_diff1", 32'(bus.diff), 32'd6);
    tick();
    bus.start = 1'b0;
    check("b2b_busy2", 32'(bus.busy), 32'd1);
    check("b2b_done_clr", 32'(bus.done), 32'd0);
    check("b2b_hold0", 32'(bus.diff), 32'd6);
    for (int i = 0; i < W - 1; i++) begin
      tick();
      check("b2b_hold", 32'(bus.diff), 32'd6);
      check("b2b_nodone", 32'(bus.done), 32'd0);
    end
    tick();
    check("b2b_done2", 32'(bus.done), 32'd1);
    check("b2b_diff2", 32'(bus.diff), 32'hA);
    check("b2b_bout2", 32'(bus.bout), 32'd1);
    tick();

    // Reset in the second RUN cycle aborts the operation.
    bus.start = 1'b1; bus.a = W'(9); bus.b = W'(3); bus.bin = 1'b0;
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_diff", 32'(bus.diff), 32'd0);
    check("abort_bout", 32'(bus.bout), 32'd0);
    for (int i = 0; i < W + 1; i++) begin
      tick();
      check("abort_nodone", 32'(bus.done), 32'd0);
    end
    run_op(7, 2, 1, 1'b1, "post_abort");

    // Randomized operations with random idle gaps.
    for (int n = 0; n < 40; n++) begin
      ra   = int'($urandom_range(0, (1 << W) - 1));
      rb   = int'($urandom_range(0, (1 << W) - 1));
      rbin = int'($urandom_range(0, 1));
      run_op(ra, rb, rbin, 1'b1, "rand");
      repeat ($urandom_range(0, 2)) tick();
    end

    // Exhaustive sweep of every operand combination.
    for (int x = 0; x < (1 << W); x++)
      for (int y = 0; y < (1 << W); y++)
        for (int z = 0; z < 2; z++)
          run_op(x, y, z, 1'b0, "exh");

    e = ref_sub(0, 1, 0);
    check("final_diff", 32'(bus.diff), 32'(e[W-1:0]) ^ 32'h0 & 32'h0 | 32'(ref_sub(15, 15, 1) & {1'b0, {W{1'b1}}}));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
